// File: rtl/evm_pkg.sv
// Shared definitions for the voting-machine display buffer: FSM encoding,
// ASCII constants, digit columns and the character template.
package evm_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  localparam logic [3:0] COL_EVEN = 4'd2;
  localparam logic [3:0] COL_ODD  = 4'd9;

  // Row layout "X:000  Y:000    ": letters at columns 0/7, digits at 2-4 and 9-11.
  function automatic logic [7:0] template_char(input logic [4:0] addr);
    logic [7:0] ch;
    case (addr[3:0])
      4'd0:                         ch = ASCII_A + {6'd0, addr[4], 1'b0};
      4'd7:                         ch = ASCII_A + {6'd0, addr[4], 1'b1};
      4'd1, 4'd8:                   ch = ASCII_COLON;
      4'd2, 4'd3, 4'd4,
      4'd9, 4'd10, 4'd11:           ch = ASCII_ZERO;
      default:                      ch = ASCII_SPACE;
    endcase
    return ch;
  endfunction

  function automatic logic [4:0] digit_addr(input logic [1:0] cand);
    return {cand[1], (cand[0] ? COL_ODD : COL_EVEN)};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one input bit per cycle,
// result valid CNT_W cycles after start.
module bin2bcd_seq
  import evm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin_in,
  output logic             done,
  output logic [3:0]       bcd_hun,
  output logic [3:0]       bcd_ten,
  output logic [3:0]       bcd_one
);

  logic [CNT_W-1:0] bin_q;
  logic [11:0]      bcd_q;
  logic [3:0]       cnt_q;
  logic [21:0]      step;

  function automatic logic [11:0] add3(input logic [11:0] bcd);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return r;
  endfunction

  assign step = {add3(bcd_q), bin_q};
  // done marks the cycle whose closing edge performs the final shift
  assign done = (cnt_q == 4'd1);
  assign bcd_hun = bcd_q[11:8];
  assign bcd_ten = bcd_q[7:4];
  assign bcd_one = bcd_q[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= 4'(CNT_W);
    end else if (cnt_q != 4'd0) begin
      bcd_q <= step[20:9];
      bin_q <= {step[8:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: rtl/evm_display_buf.sv
// Four-candidate vote tally with a 32x8 LCD character buffer; each accepted
// vote triggers a BCD conversion and a three-digit refresh of that candidate.
module evm_display_buf
  import evm_pkg::*;
#(
  parameter int MAX_COUNT = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vote_valid,
  input  logic [1:0] vote_cand,
  output logic       vote_ready,
  input  logic       clear,
  input  logic [4:0] mem_addr,
  output logic [7:0] mem_bus
);

  state_t           state_q, state_d;
  logic [1:0]       widx_q;
  logic [1:0]       cand_q;
  logic [CNT_W-1:0] tally_q [4];
  logic [7:0]       buf_q   [32];
  logic             accept, wr_en, conv_done;
  logic [CNT_W-1:0] tally_inc;
  logic [3:0]       bcd_hun, bcd_ten, bcd_one, wr_digit;
  logic [4:0]       wr_addr;

  assign tally_inc = (tally_q[vote_cand] >= CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT)
                                                               : tally_q[vote_cand] + 1'b1;

  always_comb begin
    state_d    = state_q;
    vote_ready = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        vote_ready = 1'b1;
        if (vote_valid) begin
          accept  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV:  if (conv_done) state_d = ST_WRITE;
      ST_WRITE: begin
        wr_en = 1'b1;
        if (widx_q == 2'd2) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    // clear wins over everything, including a vote at the same edge
    if (clear) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      widx_q  <= 2'd0;
      cand_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      widx_q  <= (wr_en) ? widx_q + 2'd1 : 2'd0;
      if (accept) cand_q <= vote_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) tally_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) tally_q[i] <= '0;
    end else if (accept) begin
      tally_q[vote_cand] <= tally_inc;
    end
  end

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .bin_in  (tally_inc),
    .done    (conv_done),
    .bcd_hun (bcd_hun),
    .bcd_ten (bcd_ten),
    .bcd_one (bcd_one)
  );

  // Hundreds land at the lowest address, units two bytes higher.
  assign wr_addr  = digit_addr(cand_q) + {3'd0, widx_q};
  assign wr_digit = (widx_q == 2'd0) ? bcd_hun : (widx_q == 2'd1) ? bcd_ten : bcd_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= template_char(5'(i));
    end else if (clear) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= template_char(5'(i));
    end else if (wr_en) begin
      buf_q[wr_addr] <= ASCII_ZERO + {4'd0, wr_digit};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_bus <= ASCII_SPACE;
    else     mem_bus <= buf_q[mem_addr];
  end

endmodule

// File: doc/evm_display_buf.md
EVM_DISPLAY_BUF -- requirements
Module: evm_display_buf

Interface
REQ-001 The block SHALL have parameter MAX_COUNT, default 999, the saturation limit per candidate, legal range 1..999.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port vote_valid, input, 1 bit: the vote request, sampled each rising clk edge.
REQ-005 The block SHALL have port vote_cand, input, 2 bits: the candidate index 0..3 (A..D), qualified by vote_valid.
REQ-006 The block SHALL have port vote_ready, output, 1 bit: high when the block can accept a vote.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous tally clear.
REQ-008 The block SHALL have port mem_addr, input, 5 bits: the display buffer address from the LCD driver, {row, column[3:0]}.
REQ-009 The block SHALL have port mem_bus, output, 8 bits: the ASCII character at mem_addr.

Function
REQ-010 The block SHALL hold four 10-bit tally counters and a 32x8 character buffer, with row 0 at addresses 0-15 and row 1 at addresses 16-31.
REQ-011 The buffer template SHALL be row 0 "A:ddd  B:ddd    " and row 1 "C:ddd  D:ddd    ", where ddd is a zero-padded decimal tally and unused positions hold 0x20.
REQ-012 The first digit address for candidate c SHALL be 16*c[1] + (c[0] ? 9 : 2); the hundreds digit goes at the lowest address.
REQ-013 mem_bus SHALL be a registered read: it holds buffer[mem_addr] one cycle after mem_addr is presented.
REQ-014 A vote SHALL be accepted on a rising edge where vote_valid=1, vote_ready=1 and clear=0; at that edge the tally updates to min(count+1, MAX_COUNT).
REQ-015 FSM states SHALL be IDLE, CONV and WRITE; vote_ready SHALL be 1 only in IDLE.
REQ-016 On acceptance (edge k), the FSM SHALL go IDLE->CONV and load the new tally into the converter.
REQ-017 CONV SHALL run a shift-add-3 binary-to-BCD conversion, one bit per cycle for 10 cycles (edges k+1..k+10), then go to WRITE.
REQ-018 WRITE SHALL store one ASCII digit (0x30+BCD) per cycle in order hundreds, tens, units (edges k+11..k+13), then return to IDLE, so vote_ready is high again after edge k+13.
REQ-019 A vote for a saturated candidate SHALL be accepted with the tally unchanged and SHALL still run the full refresh sequence.
REQ-020 vote_valid while vote_ready=0 SHALL be ignored without queuing; the source holds vote_valid until it sees acceptance.
REQ-021 mem_bus reads SHALL be legal at all times; during WRITE, a digit position SHALL return either its old or its new value, never any other value.
REQ-022 clear=1 at any edge, in any state, SHALL zero all tallies, restore the template with "000" digits, and force IDLE; clear SHALL take priority over a simultaneous vote, which is dropped.

Reset
REQ-023 Asserting rst SHALL immediately and asynchronously set tallies=0, buffer=template with "000", FSM=IDLE, converter registers=0 and mem_bus=0x20.
REQ-024 Reset asserted mid-CONV or mid-WRITE SHALL abort the refresh, leaving no partial digits after release.
REQ-025 vote_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-026 Shared package evm_pkg SHALL hold the FSM state encoding, the ASCII constants (space 0x20, digit base 0x30, 'A' 0x41, ':' 0x3A), the digit-column constants 2 and 9, and the count width 10.
REQ-027 The converter SHALL be the sub-module bin2bcd_seq (start, 10-bit binary in, done, 3x4-bit BCD out, 10-cycle latency), instantiated once.
REQ-028 The FSM, tallies, buffer and read port SHALL live in evm_display_buf.

Verification
REQ-029 Reset release, then sweep mem_addr 0..31 -> mem_bus spells "A:000  B:000    C:000  D:000    ".
REQ-030 One vote for candidate 2 at edge k -> vote_ready=0 from k through k+13; buffer[18..20]="001" after k+13; all other bytes unchanged.
REQ-031 Preload candidate 1 at 998, then three votes -> buffer[9..11] reads "999" after each of the last two; tally stays at 999.
REQ-032 Hold vote_valid with vote_cand=3 for 40 cycles -> exactly 3 acceptances, 14 cycles apart; D reads "003".
REQ-033 clear asserted at edge k+5 of a refresh, with vote_valid=1 at the same edge -> all digits "000", FSM IDLE, tally unchanged by the vote.
REQ-034 rst pulsed mid-WRITE -> the template is restored immediately, and the next vote produces exactly "001".
